skid_pipe_reg: RTL and testbench

- Parametrised, elastic pipeline-stage register; successor to the plain enable/clear stage registers.
- Adds a valid/ready handshake and a 2-entry skid buffer, so in_ready is fully registered and stages can stall without a combinational ready chain.
- Adds a flush input that kills in-flight entries.
- Sits between pipeline stages (IF1/IF2 … MEM/WB); WIDTH is set to the width of the packed stage struct.

---
 rtl/skid_pipe_reg_pkg.sv | 14 +
 rtl/skid_pipe_reg.sv | 73 +++++++
 tb/tb_skid_pipe_reg.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/skid_pipe_reg_pkg.sv
// skid_pipe_reg_pkg: shared state encoding and decode helpers for the elastic stage register
package skid_pipe_reg_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [1:0] occ_of(skid_state_t s);
        return s == SKID_FULL ? 2'd2 : s == SKID_BUSY ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: elastic pipeline stage with valid/ready handshake, 2-entry skid buffer and flush;
// in_ready, out_valid, occupancy and out_data all come straight from registers.
module skid_pipe_reg
    import skid_pipe_reg_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    skid_state_t      state, next_state;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             in_xfer, out_xfer;
    logic             load_main_in, load_main_skid, load_skid;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SKID_EMPTY;
        else       state <= next_state;
    end

    always_comb begin
        next_state = SKID_EMPTY;
        if (!flush) begin
            case (state)
                SKID_EMPTY: next_state = in_xfer ? SKID_BUSY : SKID_EMPTY;
                SKID_BUSY:  next_state = in_xfer ? (out_xfer ? SKID_BUSY : SKID_FULL)
                                                 : (out_xfer ? SKID_EMPTY : SKID_BUSY);
                SKID_FULL:  next_state = out_xfer ? SKID_BUSY : SKID_FULL;
                default:    next_state = SKID_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = state != SKID_FULL;
        out_valid = state != SKID_EMPTY;
        occupancy = occ_of(state);
        out_data  = main_q;
    end

    // main takes new data when it is empty or being drained in the same cycle; skid only on overflow
    assign load_main_in   = in_xfer & ((state == SKID_EMPTY) | (state == SKID_BUSY & out_xfer));
    assign load_main_skid = out_xfer & (state == SKID_FULL);
    assign load_skid      = in_xfer & ~out_xfer & (state == SKID_BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 main_q <= RESET_VALUE;
        else if (flush)            main_q <= CLEAR_ON_FLUSH ? RESET_VALUE : main_q;
        else if (load_main_in)     main_q <= in_data;
        else if (load_main_skid)   main_q <= skid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          skid_q <= RESET_VALUE;
        else if (flush)     skid_q <= CLEAR_ON_FLUSH ? RESET_VALUE : skid_q;
        else if (load_skid) skid_q <= in_data;
    end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// tb_skid_pipe_reg: table-driven directed vectors, async-reset sequence and a random scoreboard run
module tb_skid_pipe_reg;

    localparam logic [31:0] CRV = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, c_in_ready, c_out_valid;
    logic [31:0] out_data, c_out_data;
    logic [1:0]  occupancy, c_occupancy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    skid_pipe_reg #(.WIDTH(32), .RESET_VALUE(32'h0), .CLEAR_ON_FLUSH(1'b0)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    skid_pipe_reg #(.WIDTH(32), .RESET_VALUE(CRV), .CLEAR_ON_FLUSH(1'b1)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .occupancy(c_occupancy)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        f;
        logic [1:0]  occ;
        logic        ir;
        logic        ov;
        logic [31:0] od;
        logic [31:0] cd;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock: score the handshakes about to happen, advance, then check state against the model
    task automatic cyc();
        logic        ix, ox, stall;
        logic [31:0] held;
        ix    = in_valid && in_ready;
        ox    = out_valid && out_ready;
        stall = out_valid && !out_ready && !flush;
        held  = out_data;
        if (ox) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_extra: got %h expected no output", out_data);
            end else begin
                chk("sb_order", out_data, q.pop_front());
            end
        end
        if (flush) q.delete();
        else if (ix) q.push_back(in_data);
        @(posedge clk);
        #1;
        chk("occ_model", {30'd0, occupancy}, q.size());
        chk("ready_model", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("valid_model", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (stall) chk("stall_stable", out_data, held);
    endtask

    function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic f, logic [1:0] occ,
                                logic ir, logic ov, logic [31:0] od, logic [31:0] cd);
        vec_t x;
        x = '{v, d, r, f, occ, ir, ov, od, cd};
        return x;
    endfunction

    initial begin
        vecs[0]  = mk(1'b1, 32'h11, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h11, 32'h11);
        vecs[1]  = mk(1'b1, 32'h22, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h22, 32'h22);
        vecs[2]  = mk(1'b1, 32'h33, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h33, 32'h33);
        vecs[3]  = mk(1'b1, 32'h44, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h44, 32'h44);
        vecs[4]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'h44, 32'h44);
        vecs[5]  = mk(1'b1, 32'hA1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'hA1, 32'hA1);
        vecs[6]  = mk(1'b1, 32'hA2, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 32'hA1, 32'hA1);
        vecs[7]  = mk(1'b1, 32'hA3, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 32'hA1, 32'hA1);
        vecs[8]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'hA2, 32'hA2);
        vecs[9]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'hA2, 32'hA2);
        vecs[10] = mk(1'b1, 32'hB1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'hB1, 32'hB1);
        vecs[11] = mk(1'b1, 32'hB2, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 32'hB1, 32'hB1);
        vecs[12] = mk(1'b1, 32'hB3, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'hB1, CRV);
        vecs[13] = mk(1'b0, 32'h0,  1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 32'hB1, CRV);
        vecs[14] = mk(1'b1, 32'hD1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'hD1, 32'hD1);
        vecs[15] = mk(1'b1, 32'hD2, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'hD1, CRV);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_c_out_data", c_out_data, CRV);

        for (int i = 0; i < 16; i++) begin
            in_valid = vecs[i].v; in_data = vecs[i].d; out_ready = vecs[i].r; flush = vecs[i].f;
            cyc();
            chk($sformatf("v%0d_occ", i), {30'd0, occupancy}, {30'd0, vecs[i].occ});
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].ir});
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
            chk($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
            chk($sformatf("v%0d_c_out_data", i), c_out_data, vecs[i].cd);
            chk($sformatf("v%0d_c_occ", i), {30'd0, c_occupancy}, {30'd0, vecs[i].occ});
        end

        in_valid = 1'b1; in_data = 32'hC1; out_ready = 1'b0; flush = 1'b0;
        cyc();
        chk("c1_held", out_data, 32'hC1);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_occ", {30'd0, occupancy}, 32'd0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_c_out_data", c_out_data, CRV);
        #1;
        reset = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        chk("arst_after_occ", {30'd0, occupancy}, 32'd0);

        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = in_valid ? $urandom : 'x;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 99) == 0;
            cyc();
        end

        in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("drain_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
